pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, address width of the program counter and all address/count ports.
REQ-002 The block SHALL have one parameter: DEPTH, default 4, number of return-stack entries (power of two, 2..8).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset_n  input  1  synchronous active-low reset, sampled on Clk rising edge.
REQ-006 En  input  1  advance enable; 0 = hold all state (stall).
REQ-007 Jump  input  1  load PC from Target.
REQ-008 Call  input  1  push return address, load PC from Target.
REQ-009 Ret  input  1  pop return address into PC.
REQ-010 Target  input  WIDTH  jump/call destination.
REQ-011 Loop_Start  input  1  arm hardware loop: body = PC+1 .. Loop_End, run Loop_Count times.
REQ-012 Loop_End  input  WIDTH  last address of loop body.
REQ-013 Loop_Count  input  WIDTH  iteration count; 0 or 1 = body runs once.
REQ-014 Pc  output  WIDTH  current program counter (registered).
REQ-015 Sp  output  log2(DEPTH)+1  number of valid stack entries.
REQ-016 Loop_Active  output  1  hardware loop armed.
REQ-017 Halted  output  1  sequencer in HALT state.
REQ-018 Ovf  output  1  sticky: Call attempted with stack full.
REQ-019 Unf  output  1  sticky: Ret attempted with stack empty.

Function
REQ-020 State machine SHALL have states RUN, LOOP, HALT; Loop_Active = (state==LOOP); Halted = (state==HALT).
REQ-021 All state SHALL update only on Clk rising edge with En=1 and Reset_n=1; En=0 holds everything, inputs ignored.
REQ-022 Per enabled cycle exactly one PC action SHALL apply, priority Ret > Call > Jump > loop-back > increment.
REQ-023 Increment: Pc <= Pc+1 modulo 2^WIDTH (0xFF -> 0x00 for WIDTH=8, no flag).
REQ-024 Jump: Pc <= Target; stack and loop state unchanged.
REQ-025 Call with Sp<DEPTH: stack[Sp] <= Pc+1 (mod 2^WIDTH), Sp <= Sp+1, Pc <= Target.
REQ-026 Call with Sp==DEPTH: no push, Pc unchanged, Ovf <= 1, state -> HALT.
REQ-027 Ret with Sp>0: Pc <= stack[Sp-1], Sp <= Sp-1.
REQ-028 Ret with Sp==0: Pc unchanged, Unf <= 1, state -> HALT.
REQ-029 Loop_Start in RUN: capture Loop_End into end register, first-address register <= Pc+1, remaining count <= max(Loop_Count,1), Pc <= Pc+1, state -> LOOP, same cycle.
REQ-030 Loop_Start while in LOOP SHALL be ignored (no nesting); Pc action per REQ-022.
REQ-031 In LOOP, when Pc==end register and no higher-priority action: if remaining>1 then Pc <= first-address, remaining <= remaining-1; else Pc <= Pc+1, state -> RUN.
REQ-032 Jump/Call/Ret in LOOP SHALL take priority over loop-back; loop stays armed and re-triggers whenever Pc reaches end register.
REQ-033 HALT SHALL freeze Pc, Sp, stack, loop registers; all inputs ignored; exit only by reset.
REQ-034 Ovf and Unf SHALL clear only on reset.
REQ-035 Latency: every action visible on Pc the cycle after the enabling edge; no combinational input-to-output paths.

Reset
REQ-036 On Reset_n=0 at a Clk edge: Pc=0, Sp=0, state=RUN, Ovf=0, Unf=0, loop registers=0, regardless of En or other inputs.
REQ-037 Reset mid-loop or mid-HALT SHALL abandon all state per REQ-036; stack contents need not be cleared but SHALL be unreachable (Sp=0).

Verification
REQ-038 Reset then En=1 for 257 cycles -> Pc runs 0x00..0xFF, wraps to 0x00, then 0x01; no flags.
REQ-039 Pc=0x10, Call Target=0x80 -> Pc=0x80, Sp=1; next Ret -> Pc=0x11, Sp=0.
REQ-040 Five Calls (DEPTH=4) -> Sp=4 after fourth; fifth sets Ovf=1, Halted=1, Pc frozen at fourth Target; only Reset_n=0 recovers to Pc=0.
REQ-041 Ret at Sp=0 -> Unf=1, Halted=1, Pc unchanged; Sp stays 0.
REQ-042 Pc=0x20, Loop_Start End=0x22 Count=3 -> Pc sequence 21,22,21,22,21,22,23; Loop_Active high until Pc=0x23.
REQ-043 En toggled low mid-loop and simultaneous Jump+Call+Ret -> hold while En=0; Ret wins when enabled.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a call/return stack and a
// single-level hardware loop.
//
// Ports
//   Clk          rising-edge clock for all state
//   Reset_n      synchronous active-low reset
//   En           advance enable; 0 holds all state and ignores other inputs
//   Jump         load Pc from Target
//   Call         push Pc+1 and load Pc from Target
//   Ret          pop the top return address into Pc
//   Target       jump/call destination
//   Loop_Start   arm a hardware loop over Pc+1 .. Loop_End (only from RUN)
//   Loop_End     last address of the loop body
//   Loop_Count   iteration count (0 or 1 runs the body once)
//   Pc           current program counter (registered)
//   Sp           number of valid return-stack entries
//   Loop_Active  hardware loop armed (state LOOP)
//   Halted       sequencer halted after a stack fault (state HALT)
//   Ovf          sticky: Call issued with the stack full
//   Unf          sticky: Ret issued with the stack empty
//
// Per enabled cycle exactly one Pc action applies, in priority order
// Ret > Call > Jump > loop-back > increment (Loop_Start rides on increment).
module pc_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     En,
    input  logic                     Jump,
    input  logic                     Call,
    input  logic                     Ret,
    input  logic [WIDTH-1:0]         Target,
    input  logic                     Loop_Start,
    input  logic [WIDTH-1:0]         Loop_End,
    input  logic [WIDTH-1:0]         Loop_Count,
    output logic [WIDTH-1:0]         Pc,
    output logic [$clog2(DEPTH):0]   Sp,
    output logic                     Loop_Active,
    output logic                     Halted,
    output logic                     Ovf,
    output logic                     Unf
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOOP = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] loop_end_q, loop_end_d;
    logic [WIDTH-1:0] loop_first_q, loop_first_d;
    logic [WIDTH-1:0] loop_rem_q, loop_rem_d;

    logic [WIDTH-1:0] stack [DEPTH];
    logic             push;
    logic [WIDTH-1:0] pc_inc;
    logic [AW-1:0]    pop_idx;

    assign pc_inc = pc_q + 1'b1;
    // When Sp==DEPTH the low bits wrap to 0, so subtracting in AW bits still
    // lands on the top entry (DEPTH-1).
    assign pop_idx = sp_q[AW-1:0] - 1'b1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        loop_end_d   = loop_end_q;
        loop_first_d = loop_first_q;
        loop_rem_d   = loop_rem_q;
        push         = 1'b0;

        if (state_q != HALT) begin
            if (Ret) begin
                if (sp_q != '0) begin
                    pc_d = stack[pop_idx];
                    sp_d = sp_q - 1'b1;
                end else begin
                    unf_d   = 1'b1;
                    state_d = HALT;
                end
            end else if (Call) begin
                if (sp_q != SP_FULL) begin
                    push = 1'b1;
                    sp_d = sp_q + 1'b1;
                    pc_d = Target;
                end else begin
                    ovf_d   = 1'b1;
                    state_d = HALT;
                end
            end else if (Jump) begin
                pc_d = Target;
            end else if (state_q == LOOP && pc_q == loop_end_q) begin
                if (loop_rem_q > WIDTH'(1)) begin
                    pc_d       = loop_first_q;
                    loop_rem_d = loop_rem_q - 1'b1;
                end else begin
                    pc_d    = pc_inc;
                    state_d = RUN;
                end
            end else if (state_q == RUN && Loop_Start) begin
                loop_end_d   = Loop_End;
                loop_first_d = pc_inc;
                loop_rem_d   = (Loop_Count == '0) ? WIDTH'(1) : Loop_Count;
                pc_d         = pc_inc;
                state_d      = LOOP;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= RUN;
            pc_q         <= '0;
            sp_q         <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            loop_end_q   <= '0;
            loop_first_q <= '0;
            loop_rem_q   <= '0;
        end else if (En) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            loop_end_q   <= loop_end_d;
            loop_first_q <= loop_first_d;
            loop_rem_q   <= loop_rem_d;
        end
    end

    // Stack contents survive reset; Sp=0 makes them unreachable.
    always_ff @(posedge Clk) begin
        if (Reset_n && En && push) begin
            stack[sp_q[AW-1:0]] <= pc_inc;
        end
    end

    assign Pc          = pc_q;
    assign Sp          = sp_q;
    assign Loop_Active = (state_q == LOOP);
    assign Halted      = (state_q == HALT);
    assign Ovf         = ovf_q;
    assign Unf         = unf_q;

endmodule
